// File: rtl/icache_assoc_if.sv
// Fetch and refill bus bundle for icache_assoc.
//   cpu_addr / cpu_req            : fetch request from the core
//   cpu_rdata / cpu_ready         : fetched word and completion strobe
//   mem_addr / mem_req            : refill word request towards memory
//   mem_rdata / mem_valid         : refill data returned by memory
// Modport slave is the cache view; modport master is the core+memory view.
interface icache_assoc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_req;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_req;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_valid;

  modport slave (
    input  cpu_addr, cpu_req, mem_rdata, mem_valid,
    output cpu_rdata, cpu_ready, mem_addr, mem_req
  );

  modport master (
    output cpu_addr, cpu_req, mem_rdata, mem_valid,
    input  cpu_rdata, cpu_ready, mem_addr, mem_req
  );
endinterface

// File: rtl/icache_assoc.sv
// 2-way set-associative instruction cache with LRU replacement, word-serial
// line refill and a one-set-per-cycle invalidation sweep.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus (slave)           : cpu_* fetch port and mem_* refill port
//   flush                 : single-cycle invalidate-all request
//   flush_busy            : invalidation sweep in progress
//   hit_count, miss_count : saturating statistics counters
// Address split: | tag | index | word | byte(2) |
module icache_assoc #(
  parameter int NUM_SETS       = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  icache_assoc_if.slave      bus,
  input  logic               flush,
  output logic               flush_busy,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
);

  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;

  typedef enum logic [1:0] {ST_FLUSH, ST_IDLE, ST_REFILL} state_t;

  state_t state_q, state_d;

  // Storage arrays
  logic [1:0]            valid_mem [NUM_SETS];
  logic [TAG_W-1:0]      tag_mem   [NUM_SETS][2];
  logic [NUM_SETS-1:0]   lru_mem;
  logic [DATA_WIDTH-1:0] data_mem  [NUM_SETS][2][WORDS_PER_LINE];

  // Control state
  logic [IDX_W-1:0]      sweep_q;
  logic                  flush_pend_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  victim_q;

  // Request decode
  logic [WORD_W-1:0] req_word;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  assign req_word = bus.cpu_addr[OFF_W-1:2];
  assign req_idx  = bus.cpu_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag  = bus.cpu_addr[ADDR_WIDTH-1:OFF_W+IDX_W];

  // The refill address register already carries the line's index, tag and
  // the word currently being filled, so no separate copies are kept.
  logic [WORD_W-1:0] fill_word;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;

  assign fill_word = mem_addr_q[OFF_W-1:2];
  assign fill_idx  = mem_addr_q[OFF_W+IDX_W-1:OFF_W];
  assign fill_tag  = mem_addr_q[ADDR_WIDTH-1:OFF_W+IDX_W];

  logic unused_byte_bits;
  assign unused_byte_bits = ^{bus.cpu_addr[1:0], mem_addr_q[1:0]};

  // Lookup and victim selection
  logic hit0, hit1, any_hit, hit_way, victim;

  assign hit0    = valid_mem[req_idx][0] && (tag_mem[req_idx][0] == req_tag);
  assign hit1    = valid_mem[req_idx][1] && (tag_mem[req_idx][1] == req_tag);
  assign any_hit = hit0 || hit1;
  assign hit_way = hit1;
  assign victim  = !valid_mem[req_idx][0] ? 1'b0 :
                   !valid_mem[req_idx][1] ? 1'b1 : lru_mem[req_idx];

  logic                  do_hit, do_miss, fill_we, fill_done;
  logic                  ready_c;
  logic [DATA_WIDTH-1:0] rdata_c;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ready_c   = 1'b0;
    rdata_c   = '0;
    do_hit    = 1'b0;
    do_miss   = 1'b0;
    fill_we   = 1'b0;
    fill_done = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        if (sweep_q == IDX_W'(NUM_SETS - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.cpu_req && any_hit) begin
          ready_c = 1'b1;
          rdata_c = data_mem[req_idx][hit_way][req_word];
          do_hit  = 1'b1;
        end
        if (flush) begin
          state_d = ST_FLUSH;
        end else if (bus.cpu_req && !any_hit) begin
          do_miss = 1'b1;
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (bus.mem_valid) begin
          fill_we = 1'b1;
          if (fill_word == '1) begin
            fill_done = 1'b1;
            // A pending flush takes the refill straight into the sweep and
            // the fetch is not completed; the core retries after the sweep.
            if (flush_pend_q || flush) begin
              state_d = ST_FLUSH;
            end else begin
              state_d = ST_IDLE;
              if (bus.cpu_req && req_word == '1) begin
                ready_c = 1'b1;
                rdata_c = bus.mem_rdata;
              end
            end
          end
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FLUSH;
      sweep_q      <= '0;
      flush_pend_q <= 1'b0;
      mem_addr_q   <= '0;
      victim_q     <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= (state_q == ST_FLUSH) ? sweep_q + IDX_W'(1) : '0;

      if (state_q == ST_REFILL && !fill_done) flush_pend_q <= flush_pend_q | flush;
      else                                    flush_pend_q <= 1'b0;

      if (do_miss) begin
        mem_addr_q <= {bus.cpu_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        victim_q   <= victim;
      end else if (fill_we) begin
        mem_addr_q <= mem_addr_q + ADDR_WIDTH'(4);
      end

      if (do_hit && hit_count != '1)   hit_count  <= hit_count + 32'd1;
      if (do_miss && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end

  // NOTE: the arrays carry no reset; the sweep that always follows reset
  // clears valid and LRU, and tags/data are never read while invalid.
  always_ff @(posedge clk) begin
    if (state_q == ST_FLUSH) begin
      valid_mem[sweep_q] <= 2'b00;
      lru_mem[sweep_q]   <= 1'b0;
    end else begin
      if (do_hit) lru_mem[req_idx] <= ~hit_way;
      if (fill_done) begin
        valid_mem[fill_idx][victim_q] <= 1'b1;
        tag_mem[fill_idx][victim_q]   <= fill_tag;
        lru_mem[fill_idx]             <= ~victim_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) data_mem[fill_idx][victim_q][fill_word] <= bus.mem_rdata;
  end

  assign bus.cpu_ready = ready_c;
  assign bus.cpu_rdata = rdata_c;
  assign bus.mem_req   = (state_q == ST_REFILL);
  assign bus.mem_addr  = mem_addr_q;
  assign flush_busy    = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc (NUM_SETS=16, WORDS_PER_LINE=4).
// Memory returns a fixed function of the word address; the cache contents are
// modelled as a per-set recency list of line addresses.
module tb_icache_assoc;

  localparam int NS  = 16;
  localparam int WPL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        flush_busy;
  logic [31:0] hit_count, miss_count;

  icache_assoc_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  icache_assoc #(
    .NUM_SETS(NS), .WORDS_PER_LINE(WPL), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .flush_busy(flush_busy), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // ---------------- memory responder ----------------
  int          gap_max  = 0;
  int          gap_left = 0;
  logic [31:0] acc_q[$];
  bit          gap_seen = 0;
  logic [31:0] gap_addr;

  always begin
    @(posedge clk); #1;
    bus.mem_rdata = mem_word(bus.mem_addr);
    if (bus.mem_req && gap_left == 0) begin
      bus.mem_valid = 1'b1;
      gap_left = $urandom_range(gap_max, 0);
    end else begin
      bus.mem_valid = 1'b0;
      if (gap_left > 0) gap_left--;
    end
    @(negedge clk);
    if (bus.mem_req) begin
      if (gap_seen) check("mem_addr_gap", bus.mem_addr, gap_addr);
      if (bus.mem_valid) begin
        acc_q.push_back(bus.mem_addr);
        gap_seen = 0;
      end else begin
        gap_seen = 1;
        gap_addr = bus.mem_addr;
      end
    end else begin
      gap_seen = 0;
    end
  end

  // ---------------- reference model ----------------
  // m_line[s][0] is the least recently used line, [1] the most recent.
  logic [31:0] m_line[NS][2];
  int          m_cnt[NS];

  function automatic void model_clear();
    for (int s = 0; s < NS; s++) m_cnt[s] = 0;
  endfunction

  function automatic bit model_access(input logic [31:0] a);
    int s;
    logic [31:0] line;
    s    = int'(a[7:4]);
    line = a & ~32'hF;
    for (int i = 0; i < m_cnt[s]; i++) begin
      if (m_line[s][i] == line) begin
        if (i == 0 && m_cnt[s] == 2) begin
          m_line[s][0] = m_line[s][1];
          m_line[s][1] = line;
        end
        return 1'b1;
      end
    end
    if (m_cnt[s] < 2) begin
      m_line[s][m_cnt[s]] = line;
      m_cnt[s]++;
    end else begin
      m_line[s][0] = m_line[s][1];
      m_line[s][1] = line;
    end
    return 1'b0;
  endfunction

  // ---------------- transaction tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic fetch(input logic [31:0] addr, input bit exp_hit);
    bit got, first;
    logic [31:0] data;
    got = 0; first = 0; data = '0;
    acc_q.delete();
    bus.cpu_addr = addr;
    bus.cpu_req  = 1'b1;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        got   = 1;
        first = (c == 0);
        data  = bus.cpu_rdata;
      end
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b0;
    check("ready_seen", got, 1);
    check("hit_same_cycle", first, exp_hit);
    check("rdata", data, mem_word(addr));
    if (!exp_hit) begin
      check("refill_len", acc_q.size(), WPL);
      for (int k = 0; k < WPL; k++)
        if (k < acc_q.size()) check("refill_addr", acc_q[k], (addr & ~32'hF) + 32'(4 * k));
    end
    if (!exp_hit) exp_misses++;
    if (exp_hit || addr[3:2] != 2'd3) exp_hits++;
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
  endtask

  task automatic count_busy(output int n);
    bit done;
    n = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (flush_busy) n++;
      else done = 1;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_flush();
    int n;
    flush = 1'b1;
    @(negedge clk);
    check("busy_on_pulse", flush_busy, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    count_busy(n);
    check("flush_len", n, NS);
    model_clear();
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [31:0] addr;
    bit          hit;
    int          hits;
    int          misses;
  } vec_t;

  vec_t        tbl[11];
  logic [31:0] raddr[40];
  logic [31:0] dh[2], dm[2];

  initial begin
    int n;
    bit fired, saw_ready, done;

    tbl[0]  = '{32'h0000_0104, 1'b0, 1, 1};
    tbl[1]  = '{32'h0000_0108, 1'b1, 2, 1};
    tbl[2]  = '{32'h0000_1000, 1'b0, 3, 2};
    tbl[3]  = '{32'h0000_2000, 1'b0, 4, 3};
    tbl[4]  = '{32'h0000_1000, 1'b1, 5, 3};
    tbl[5]  = '{32'h0000_3000, 1'b0, 6, 4};
    tbl[6]  = '{32'h0000_1000, 1'b1, 7, 4};
    tbl[7]  = '{32'h0000_2000, 1'b0, 8, 5};
    tbl[8]  = '{32'h0000_010C, 1'b0, 8, 6};
    tbl[9]  = '{32'h0000_010C, 1'b1, 9, 6};
    tbl[10] = '{32'h0000_2008, 1'b1, 10, 6};

    rst_n = 1'b0; flush = 1'b0;
    bus.cpu_addr = '0; bus.cpu_req = 1'b0;
    bus.mem_rdata = '0; bus.mem_valid = 1'b0;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flush_busy", flush_busy, 1);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_cpu_ready", bus.cpu_ready, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_busy(n);
    check("reset_sweep_len", n, NS);

    // Table-driven basic sequence
    for (int i = 0; i < 11; i++) begin
      fetch(tbl[i].addr, tbl[i].hit);
      check("tbl_hits", hit_count, tbl[i].hits);
      check("tbl_misses", miss_count, tbl[i].misses);
    end

    // Flush arriving while a refill is in progress
    do_flush();
    fetch(32'h0000_1040, 1'b0);
    fetch(32'h0000_1044, 1'b1);
    acc_q.delete();
    bus.cpu_addr = 32'h0000_2050;
    bus.cpu_req  = 1'b1;
    fired = 0; saw_ready = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (bus.cpu_ready) saw_ready = 1;
      if (flush_busy) done = 1;
      @(posedge clk); #1;
      if (!fired && acc_q.size() == 1) begin
        flush = 1'b1;
        fired = 1;
      end else begin
        flush = 1'b0;
      end
    end
    bus.cpu_req = 1'b0;
    flush = 1'b0;
    check("flush_pend_no_ready", saw_ready, 0);
    check("flush_pend_refill_len", acc_q.size(), WPL);
    check("flush_pend_entered", done, 1);
    count_busy(n);
    check("flush_pend_sweep_len", n + 1, NS);
    exp_misses++;
    model_clear();
    fetch(32'h0000_1040, 1'b0);

    // Reset in the middle of a refill
    acc_q.delete();
    bus.cpu_addr = 32'h0000_3070;
    bus.cpu_req  = 1'b1;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (acc_q.size() >= 2) done = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("mid_refill_reached", done, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", bus.mem_req, 0);
    check("rst_mid_mem_addr", bus.mem_addr, 0);
    check("rst_mid_busy", flush_busy, 1);
    check("rst_mid_hits", hit_count, 0);
    check("rst_mid_misses", miss_count, 0);
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_hits = 0; exp_misses = 0;
    model_clear();
    count_busy(n);
    check("rst_mid_sweep_len", n, NS);
    fetch(32'h0000_3070, model_access(32'h0000_3070));

    // Random traffic, once gap-free and once with memory gaps
    for (int i = 0; i < 40; i++)
      raddr[i] = (32'($urandom_range(2, 0)) << 8) | (32'($urandom_range(3, 0)) << 4) |
                 (32'($urandom_range(3, 0)) << 2);
    for (int run = 0; run < 2; run++) begin
      logic [31:0] h0, m0;
      gap_max = (run == 0) ? 0 : 5;
      do_flush();
      h0 = hit_count;
      m0 = miss_count;
      for (int i = 0; i < 40; i++) fetch(raddr[i], model_access(raddr[i]));
      dh[run] = hit_count - h0;
      dm[run] = miss_count - m0;
    end
    check("gap_run_hits_equal", dh[1], dh[0]);
    check("gap_run_misses_equal", dm[1], dm[0]);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
